// File: rtl/sliced_adder_fsm.sv
// sliced_adder_fsm: multi-cycle add/sub, SLICE bits per clock.
// Ports: CLK, rst (sync, high); start/abort/sub/cin, a, b in;
//        busy, done, sum, cout, ovf out (all registered).
module sliced_adder_fsm #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW =
    (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] a_sh, a_d;
  logic [WIDTH-1:0] b_sh, b_d;
  logic [WIDTH-1:0] r_sh, r_d;
  logic             carry, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;
  logic             busy_d, done_d;
  logic             load;

  logic [SLICE:0]   sl;
  logic [WIDTH-1:0] r_nx;
  logic             c_msb;

  assign sl = {1'b0, a_sh[SLICE-1:0]}
            + {1'b0, b_sh[SLICE-1:0]}
            + {{SLICE{1'b0}}, carry};

  // New slice enters at the top; after NSLICE
  // shifts the first slice sits at bit 0.
  assign r_nx = (r_sh >> SLICE)
              | (WIDTH'(sl[SLICE-1:0])
                 << (WIDTH - SLICE));

  // Carry into the slice MSB recovered from
  // its sum bit (equals carry-in when SLICE=1).
  assign c_msb = a_sh[SLICE-1]
               ^ b_sh[SLICE-1]
               ^ sl[SLICE-1];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = a_sh;
    b_d     = b_sh;
    r_d     = r_sh;
    carry_d = carry;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = ovf;
    load    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) load = 1'b1;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d     = a_sh >> SLICE;
          b_d     = b_sh >> SLICE;
          r_d     = r_nx;
          carry_d = sl[SLICE];
          cnt_d   = cnt + 1'b1;
          if (cnt == LAST) begin
            sum_d   = r_nx;
            cout_d  = sl[SLICE];
            ovf_d   = c_msb ^ sl[SLICE];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) load = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      a_sh  <= a_d;
      b_sh  <= b_d;
      r_sh  <= r_d;
      carry <= carry_d;
      sum   <= sum_d;
      cout  <= cout_d;
      ovf   <= ovf_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule
